// File: rtl/i2c_burst_master_model_if.sv
// Word handshake plus serial-line bundle for i2c_burst_master_model.
// "master" is the view of the burst master itself; "slave" is the view of whatever drives it.
interface i2c_burst_master_model_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] DIN;
  logic              DIN_VALID;
  logic              LAST;
  logic              PERFORM_READ;
  logic              DIN_READY;
  logic              SDA_IN;
  logic              DATA_OUT;
  logic              SCLK;
  logic [DATA_W-1:0] DOUT;
  logic              DOUT_VALID;
  logic              BUSY;
  logic              DONE;
  logic              ACK_ERR;

  modport master (
    input  DIN, DIN_VALID, LAST, PERFORM_READ, SDA_IN,
    output DIN_READY, DATA_OUT, SCLK, DOUT, DOUT_VALID, BUSY, DONE, ACK_ERR
  );

  modport slave (
    output DIN, DIN_VALID, LAST, PERFORM_READ, SDA_IN,
    input  DIN_READY, DATA_OUT, SCLK, DOUT, DOUT_VALID, BUSY, DONE, ACK_ERR
  );
endinterface

// File: rtl/i2c_burst_master_model.sv
// Bit-banged I2C-style burst master: serialises DATA_W-bit write/read words, each with an ACK slot.
// Optional macro I2C_ACK_CHECK_EN: a write NACK sets ACK_ERR and ends the burst early.
module i2c_burst_master_model #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CLK_DIV   = 4,
  parameter bit          LSB_FIRST = 1'b0
) (
  input logic                      CLK,
  input logic                      RST_N,
  i2c_burst_master_model_if.master bus
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StBitLo, StBitHi, StAckLo, StAckHi, StNext, StFinish
  } state_e;

  state_e            r_state, w_state_nxt;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shift, r_rx, r_dout;
  logic              r_last, r_read, r_data_out, r_dout_valid;

  logic              w_din_ready, w_accept, w_phase, w_phase_end, w_last_bit, w_abort;
  logic [DATA_W-1:0] w_shift_nxt, w_rx_nxt;

  function automatic logic first_bit(input logic [DATA_W-1:0] v);
    return LSB_FIRST ? v[0] : v[DATA_W-1];
  endfunction

  assign w_din_ready = (r_state == StIdle) || (r_state == StNext);
  assign w_accept    = w_din_ready && bus.DIN_VALID;
  assign w_phase     = r_state inside {StBitLo, StBitHi, StAckLo, StAckHi};
  assign w_phase_end = w_phase && (r_div_cnt == DIV_LAST);
  assign w_last_bit  = (r_bit_cnt == BIT_LAST);
  assign w_shift_nxt = LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);
  // Received bits enter at the end opposite to where the first one must finally sit.
  assign w_rx_nxt    = LSB_FIRST ? ((r_rx >> 1) | (DATA_W'(bus.SDA_IN) << (DATA_W - 1)))
                                 : ((r_rx << 1) | DATA_W'(bus.SDA_IN));

`ifdef I2C_ACK_CHECK_EN
  logic r_ack_err;
  logic w_nack;

  assign w_nack      = !r_read && bus.SDA_IN;
  assign w_abort     = w_nack;
  assign bus.ACK_ERR = r_ack_err;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ack_err <= 1'b0;
    end else if (w_accept && (r_state == StIdle)) begin
      r_ack_err <= 1'b0;
    end else if ((r_state == StAckHi) && w_phase_end && w_nack) begin
      r_ack_err <= 1'b1;
    end
  end
`else
  assign w_abort     = 1'b0;
  assign bus.ACK_ERR = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle, StNext: if (w_accept) w_state_nxt = StLoad;
      StLoad:         w_state_nxt = StBitLo;
      StBitLo:        if (w_phase_end) w_state_nxt = StBitHi;
      StBitHi:        if (w_phase_end) w_state_nxt = w_last_bit ? StAckLo : StBitLo;
      StAckLo:        if (w_phase_end) w_state_nxt = StAckHi;
      StAckHi:        if (w_phase_end) w_state_nxt = (r_last || w_abort) ? StFinish : StNext;
      StFinish:       w_state_nxt = StIdle;
      default:        w_state_nxt = StIdle;
    endcase
  end

  // Every SCLK phase ends exactly when the divider wraps, so it simply restarts at zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_div_cnt <= '0;
    end else if (w_phase && !w_phase_end) begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end else begin
      r_div_cnt <= '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_shift      <= '0;
      r_rx         <= '0;
      r_dout       <= '0;
      r_bit_cnt    <= '0;
      r_last       <= 1'b0;
      r_read       <= 1'b0;
      r_data_out   <= 1'b0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      if (w_accept) begin
        r_shift    <= bus.DIN;
        r_rx       <= '0;
        r_last     <= bus.LAST;
        r_read     <= bus.PERFORM_READ;
        r_bit_cnt  <= '0;
        r_data_out <= bus.PERFORM_READ ? 1'b1 : first_bit(bus.DIN);
      end else if ((r_state == StBitHi) && w_phase_end) begin
        if (r_read) r_rx <= w_rx_nxt;
        if (w_last_bit) begin
          // ACK slot: a reader ACKs all but the final word, a writer releases the line.
          r_data_out <= r_read ? r_last : 1'b1;
        end else begin
          r_bit_cnt  <= r_bit_cnt + 1'b1;
          r_shift    <= w_shift_nxt;
          r_data_out <= r_read ? 1'b1 : first_bit(w_shift_nxt);
        end
      end else if ((r_state == StAckHi) && w_phase_end && r_read) begin
        r_dout       <= r_rx;
        r_dout_valid <= 1'b1;
      end
    end
  end

  assign bus.DIN_READY  = w_din_ready;
  assign bus.SCLK       = (r_state == StBitHi) || (r_state == StAckHi);
  assign bus.DATA_OUT   = r_data_out;
  assign bus.DOUT       = r_dout;
  assign bus.DOUT_VALID = r_dout_valid;
  assign bus.BUSY       = (r_state != StIdle);
  assign bus.DONE       = (r_state == StFinish);

endmodule

// File: tb/tb_i2c_burst_master_model.sv
// Directed bench for i2c_burst_master_model: an 8-bit MSB-first instance and a 4-bit LSB-first one.
module tb_i2c_burst_master_model;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  i2c_burst_master_model_if #(.DATA_W(8)) bus8();
  i2c_burst_master_model_if #(.DATA_W(4)) bus4();

  i2c_burst_master_model #(.DATA_W(8), .CLK_DIV(4), .LSB_FIRST(1'b0)) u_dut8 (
    .CLK(clk), .RST_N(rst_n), .bus(bus8)
  );
  i2c_burst_master_model #(.DATA_W(4), .CLK_DIV(1), .LSB_FIRST(1'b1)) u_dut4 (
    .CLK(clk), .RST_N(rst_n), .bus(bus4)
  );

  assign bus4.SDA_IN = 1'b0;

  // Line observers and slave data source, sampled on the falling edge.
  int          m8_pulses = 0, m8_hi = 0, m8_bad_w = 0, m8_hi_chg = 0;
  int          m8_done = 0, m8_clash = 0, m8_dv = 0;
  logic [63:0] m8_vec = '0;
  logic        m8_sclk_q = 1'b0, m8_do_q = 1'b0;
  logic [7:0]  m8_dq[$];
  logic [63:0] sda_plan;
  int          sda_base;

  always @(negedge clk) begin
    int k;
    if (!rst_n) bus8.SDA_IN = 1'b0;
    if (bus8.SCLK && !m8_sclk_q) begin
      m8_pulses++;
      m8_hi  = 1;
      m8_vec = {m8_vec[62:0], bus8.DATA_OUT};
      k = m8_pulses - sda_base - 1;
      bus8.SDA_IN = (k >= 0 && k < 64) ? sda_plan[63-k] : 1'b0;
    end else if (bus8.SCLK) begin
      m8_hi++;
      if (bus8.DATA_OUT !== m8_do_q) m8_hi_chg++;
    end else if (m8_sclk_q && m8_hi != 4) begin
      m8_bad_w++;
    end
    if (bus8.DONE) m8_done++;
    if (bus8.DONE && bus8.DIN_READY) m8_clash++;
    if (bus8.DOUT_VALID) begin
      m8_dv++;
      m8_dq.push_back(bus8.DOUT);
    end
    m8_sclk_q = bus8.SCLK;
    m8_do_q   = bus8.DATA_OUT;
  end

  int          m4_pulses = 0, m4_hi = 0, m4_bad_w = 0, m4_done = 0;
  logic [63:0] m4_vec = '0;
  logic        m4_sclk_q = 1'b0;

  always @(negedge clk) begin
    if (bus4.SCLK && !m4_sclk_q) begin
      m4_pulses++;
      m4_hi  = 1;
      m4_vec = {m4_vec[62:0], bus4.DATA_OUT};
    end else if (bus4.SCLK) begin
      m4_hi++;
    end else if (m4_sclk_q && m4_hi != 1) begin
      m4_bad_w++;
    end
    if (bus4.DONE) m4_done++;
    m4_sclk_q = bus4.SCLK;
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send8(input logic [7:0] d, input logic last, input logic rd, output bit ok);
    bit rdy;
    int n = 0;
    bus8.DIN = d; bus8.LAST = last; bus8.PERFORM_READ = rd; bus8.DIN_VALID = 1'b1;
    do begin
      rdy = bus8.DIN_READY;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 400);
    bus8.DIN_VALID = 1'b0; bus8.DIN = ~d; bus8.LAST = ~last; bus8.PERFORM_READ = ~rd;
    ok = rdy;
  endtask

  task automatic send4(input logic [3:0] d, input logic last, output bit ok);
    bit rdy;
    int n = 0;
    bus4.DIN = d; bus4.LAST = last; bus4.PERFORM_READ = 1'b0; bus4.DIN_VALID = 1'b1;
    do begin
      rdy = bus4.DIN_READY;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 400);
    bus4.DIN_VALID = 1'b0; bus4.DIN = ~d; bus4.LAST = ~last;
    ok = rdy;
  endtask

  task automatic wait_done8(input int target, output bit ok);
    int n = 0;
    while (m8_done < target && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (m8_done >= target);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sda_plan = '0; sda_base = 0;
    bus8.DIN = '0; bus8.DIN_VALID = 1'b0; bus8.LAST = 1'b0; bus8.PERFORM_READ = 1'b0;
    bus4.DIN = '0; bus4.DIN_VALID = 1'b0; bus4.LAST = 1'b0; bus4.PERFORM_READ = 1'b0;
    #12;
    n_cmp++; if (bus8.SCLK !== 1'b0) begin n_fail++; $display("FAIL rst_sclk: got %b want 0", bus8.SCLK); end
    n_cmp++; if (bus8.DATA_OUT !== 1'b0) begin n_fail++; $display("FAIL rst_data_out: got %b want 0", bus8.DATA_OUT); end
    n_cmp++; if (bus8.DOUT !== 8'h00) begin n_fail++; $display("FAIL rst_dout: got %h want 00", bus8.DOUT); end
    n_cmp++; if (bus8.DOUT_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_dout_valid: got %b want 0", bus8.DOUT_VALID); end
    n_cmp++; if (bus8.DONE !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus8.DONE); end
    n_cmp++; if (bus8.ACK_ERR !== 1'b0) begin n_fail++; $display("FAIL rst_ack_err: got %b want 0", bus8.ACK_ERR); end
    n_cmp++; if (bus8.BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus8.BUSY); end
    n_cmp++; if (bus4.SCLK !== 1'b0) begin n_fail++; $display("FAIL rst_sclk4: got %b want 0", bus4.SCLK); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus8.DIN_READY !== 1'b1) begin n_fail++; $display("FAIL rst_din_ready: got %b want 1", bus8.DIN_READY); end
    n_cmp++; if (bus4.DIN_READY !== 1'b1) begin n_fail++; $display("FAIL rst_din_ready4: got %b want 1", bus4.DIN_READY); end
  endtask

  task automatic test_write_single();
    bit ok;
    int p0 = m8_pulses, d0 = m8_done, w0 = m8_bad_w, h0 = m8_hi_chg;
    sda_plan = '0; sda_base = m8_pulses;
    send8(8'hA5, 1'b1, 1'b0, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL a5_accept: got timeout want accept"); end
    n_cmp++; if (bus8.DATA_OUT !== 1'b1 || bus8.SCLK !== 1'b0) begin
      n_fail++; $display("FAIL a5_load: got data_out=%b sclk=%b want 1/0", bus8.DATA_OUT, bus8.SCLK);
    end
    wait_done8(d0 + 1, ok);
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if (m8_vec[8:0] !== {8'hA5, 1'b1}) begin
      n_fail++; $display("FAIL a5_bits: got %b want %b", m8_vec[8:0], {8'hA5, 1'b1});
    end
    n_cmp++; if (m8_pulses - p0 !== 9) begin n_fail++; $display("FAIL a5_pulses: got %0d want 9", m8_pulses - p0); end
    n_cmp++; if (m8_bad_w - w0 !== 0) begin n_fail++; $display("FAIL a5_width: got %0d bad pulses want 0", m8_bad_w - w0); end
    n_cmp++; if (m8_hi_chg - h0 !== 0) begin n_fail++; $display("FAIL a5_stable: got %0d changes want 0", m8_hi_chg - h0); end
    n_cmp++; if (m8_done - d0 !== 1) begin n_fail++; $display("FAIL a5_done: got %0d want 1", m8_done - d0); end
    n_cmp++; if (bus8.ACK_ERR !== 1'b0) begin n_fail++; $display("FAIL a5_ack_err: got %b want 0", bus8.ACK_ERR); end
    n_cmp++; if (bus8.BUSY !== 1'b0) begin n_fail++; $display("FAIL a5_busy: got %b want 0", bus8.BUSY); end
  endtask

  task automatic test_back_to_back();
    bit ok, ok2, ok3;
    int n = 0, bad = 0;
    int p0 = m8_pulses, d0 = m8_done, c0 = m8_clash;
    sda_plan = '0; sda_base = m8_pulses;
    send8(8'h12, 1'b0, 1'b0, ok);
    while (!(bus8.BUSY && bus8.DIN_READY) && n < 200) begin @(posedge clk); #1; n++; end
    n_cmp++; if (!(bus8.BUSY && bus8.DIN_READY)) begin n_fail++; $display("FAIL b2b_next: got no wait state want NEXT"); end
    repeat (10) begin
      if (bus8.SCLK !== 1'b0 || bus8.DIN_READY !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_idle_sclk: got %0d bad cycles want 0", bad); end
    send8(8'h34, 1'b0, 1'b0, ok2);
    send8(8'h56, 1'b1, 1'b0, ok3);
    n_cmp++; if (!(ok && ok2 && ok3)) begin n_fail++; $display("FAIL b2b_accept: got %b%b%b want 111", ok, ok2, ok3); end
    wait_done8(d0 + 1, ok);
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if (m8_pulses - p0 !== 27) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 27", m8_pulses - p0); end
    n_cmp++; if (m8_vec[26:0] !== {8'h12, 1'b1, 8'h34, 1'b1, 8'h56, 1'b1}) begin
      n_fail++; $display("FAIL b2b_bits: got %h want %h", m8_vec[26:0], {8'h12, 1'b1, 8'h34, 1'b1, 8'h56, 1'b1});
    end
    n_cmp++; if (m8_done - d0 !== 1) begin n_fail++; $display("FAIL b2b_done: got %0d want 1", m8_done - d0); end
    n_cmp++; if (m8_clash - c0 !== 0) begin n_fail++; $display("FAIL b2b_done_ready: got %0d want 0", m8_clash - c0); end
  endtask

  task automatic test_read();
    bit ok, ok2;
    int d0 = m8_done, v0 = m8_dv, q0 = m8_dq.size();
    logic [7:0] r0, r1;
    sda_plan = {8'h3C, 1'b1, 8'hC3, 1'b1, 46'd0}; sda_base = m8_pulses;
    send8(8'h00, 1'b0, 1'b1, ok);
    send8(8'h00, 1'b1, 1'b1, ok2);
    n_cmp++; if (!(ok && ok2)) begin n_fail++; $display("FAIL rd_accept: got %b%b want 11", ok, ok2); end
    wait_done8(d0 + 1, ok);
    repeat (3) begin @(posedge clk); #1; end
    r0 = (m8_dq.size() > q0) ? m8_dq[q0] : 8'h00;
    r1 = (m8_dq.size() > q0 + 1) ? m8_dq[q0+1] : 8'h00;
    n_cmp++; if (m8_dv - v0 !== 2) begin n_fail++; $display("FAIL rd_valid_count: got %0d want 2", m8_dv - v0); end
    n_cmp++; if (r0 !== 8'h3C) begin n_fail++; $display("FAIL rd_word0: got %h want 3c", r0); end
    n_cmp++; if (r1 !== 8'hC3) begin n_fail++; $display("FAIL rd_word1: got %h want c3", r1); end
    n_cmp++; if (m8_vec[17:0] !== {8'hFF, 1'b0, 8'hFF, 1'b1}) begin
      n_fail++; $display("FAIL rd_line: got %b want %b", m8_vec[17:0], {8'hFF, 1'b0, 8'hFF, 1'b1});
    end
    n_cmp++; if (bus8.DOUT !== 8'hC3) begin n_fail++; $display("FAIL rd_dout_hold: got %h want c3", bus8.DOUT); end
    n_cmp++; if (m8_done - d0 !== 1) begin n_fail++; $display("FAIL rd_done: got %0d want 1", m8_done - d0); end
  endtask

  task automatic test_ack_nack();
    bit ok;
    bit reached = 1'b0;
    int n = 0;
    int p0 = m8_pulses, d0 = m8_done;
    sda_plan = {8'h00, 1'b1, 8'h00, 1'b0, 46'd0}; sda_base = m8_pulses;
    send8(8'h11, 1'b0, 1'b0, ok);
    while (!reached && m8_done == d0 && n < 200) begin
      if (bus8.BUSY && bus8.DIN_READY) reached = 1'b1;
      else begin @(posedge clk); #1; n++; end
    end
`ifdef I2C_ACK_CHECK_EN
    n_cmp++; if (reached !== 1'b0) begin n_fail++; $display("FAIL nack_next: got %b want 0", reached); end
    wait_done8(d0 + 1, ok);
    repeat (5) begin @(posedge clk); #1; end
    n_cmp++; if (m8_pulses - p0 !== 9) begin n_fail++; $display("FAIL nack_pulses: got %0d want 9", m8_pulses - p0); end
    n_cmp++; if (m8_vec[8:0] !== {8'h11, 1'b1}) begin n_fail++; $display("FAIL nack_bits: got %b want %b", m8_vec[8:0], {8'h11, 1'b1}); end
    n_cmp++; if (m8_done - d0 !== 1) begin n_fail++; $display("FAIL nack_done: got %0d want 1", m8_done - d0); end
    n_cmp++; if (bus8.ACK_ERR !== 1'b1) begin n_fail++; $display("FAIL nack_sticky: got %b want 1", bus8.ACK_ERR); end
    sda_plan = '0; sda_base = m8_pulses;
    send8(8'h5A, 1'b1, 1'b0, ok);
    n_cmp++; if (bus8.ACK_ERR !== 1'b0) begin n_fail++; $display("FAIL nack_clear: got %b want 0", bus8.ACK_ERR); end
    wait_done8(d0 + 2, ok);
`else
    n_cmp++; if (reached !== 1'b1) begin n_fail++; $display("FAIL nack_next: got %b want 1", reached); end
    send8(8'h22, 1'b1, 1'b0, ok);
    wait_done8(d0 + 1, ok);
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if (m8_pulses - p0 !== 18) begin n_fail++; $display("FAIL nack_pulses: got %0d want 18", m8_pulses - p0); end
    n_cmp++; if (m8_vec[17:0] !== {8'h11, 1'b1, 8'h22, 1'b1}) begin
      n_fail++; $display("FAIL nack_bits: got %b want %b", m8_vec[17:0], {8'h11, 1'b1, 8'h22, 1'b1});
    end
    n_cmp++; if (m8_done - d0 !== 1) begin n_fail++; $display("FAIL nack_done: got %0d want 1", m8_done - d0); end
    n_cmp++; if (bus8.ACK_ERR !== 1'b0) begin n_fail++; $display("FAIL nack_ack_err: got %b want 0", bus8.ACK_ERR); end
`endif
  endtask

  task automatic test_lsb_first();
    bit ok;
    int n = 0;
    int p0 = m4_pulses, d0 = m4_done, w0 = m4_bad_w;
    send4(4'h6, 1'b1, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL lsb_accept: got timeout want accept"); end
    while (m4_done == d0 && n < 100) begin @(posedge clk); #1; n++; end
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if (m4_vec[4:0] !== 5'b01101) begin n_fail++; $display("FAIL lsb_bits: got %b want 01101", m4_vec[4:0]); end
    n_cmp++; if (m4_pulses - p0 !== 5) begin n_fail++; $display("FAIL lsb_pulses: got %0d want 5", m4_pulses - p0); end
    n_cmp++; if (m4_bad_w - w0 !== 0) begin n_fail++; $display("FAIL lsb_width: got %0d bad pulses want 0", m4_bad_w - w0); end
    n_cmp++; if (m4_done - d0 !== 1) begin n_fail++; $display("FAIL lsb_done: got %0d want 1", m4_done - d0); end
  endtask

  task automatic test_reset_mid_word();
    bit ok;
    int n = 0;
    int p0 = m8_pulses, d0, v0;
    sda_plan = '0; sda_base = m8_pulses;
    send8(8'hFF, 1'b1, 1'b0, ok);
    while (m8_pulses - p0 < 4 && n < 200) begin @(posedge clk); #1; n++; end
    #2 rst_n = 1'b0;
    #1;
    d0 = m8_done; v0 = m8_dv;
    n_cmp++; if (bus8.SCLK !== 1'b0 || bus8.DATA_OUT !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_lines: got sclk=%b data_out=%b want 0/0", bus8.SCLK, bus8.DATA_OUT);
    end
    n_cmp++; if (bus8.BUSY !== 1'b0 || bus8.DONE !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_status: got busy=%b done=%b want 0/0", bus8.BUSY, bus8.DONE);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    n_cmp++; if (m8_done - d0 !== 0 || m8_dv - v0 !== 0) begin
      n_fail++; $display("FAIL mid_rst_pulses: got done=%0d dv=%0d want 0/0", m8_done - d0, m8_dv - v0);
    end
    n_cmp++; if (bus8.DIN_READY !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 1", bus8.DIN_READY); end
    p0 = m8_pulses; d0 = m8_done;
    sda_plan = '0; sda_base = m8_pulses;
    send8(8'h81, 1'b1, 1'b0, ok);
    wait_done8(d0 + 1, ok);
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if (m8_vec[8:0] !== {8'h81, 1'b1}) begin
      n_fail++; $display("FAIL mid_rst_next_bits: got %b want %b", m8_vec[8:0], {8'h81, 1'b1});
    end
    n_cmp++; if (m8_pulses - p0 !== 9) begin n_fail++; $display("FAIL mid_rst_next_pulses: got %0d want 9", m8_pulses - p0); end
    n_cmp++; if (m8_done - d0 !== 1) begin n_fail++; $display("FAIL mid_rst_next_done: got %0d want 1", m8_done - d0); end
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_back_to_back();
    test_read();
    test_ack_nack();
    test_lsb_first();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2c_burst_master_model.md
I2C_BURST_MASTER_MODEL -- requirements
Module: i2c_burst_master_model

Interface
REQ-001 SHALL have parameter DATA_W, default 8, bits per word (legal 1..32).
REQ-002 SHALL have parameter CLK_DIV, default 4, CLK cycles per SCLK half-period (legal >=1).
REQ-003 SHALL have parameter LSB_FIRST, default 0: 0 = MSB first, 1 = LSB first.
REQ-004 SHALL have port CLK  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port DIN  input  DATA_W  word to transmit.
REQ-007 SHALL have port DIN_VALID  input  1  DIN/LAST/PERFORM_READ valid.
REQ-008 SHALL have port LAST  input  1  accepted word is final word of burst.
REQ-009 SHALL have port PERFORM_READ  input  1  accepted word is a read slot.
REQ-010 SHALL have port DIN_READY  output  1  block accepts a word this cycle.
REQ-011 SHALL have port SDA_IN  input  1  sampled serial data line.
REQ-012 SHALL have port DATA_OUT  output  1  serial data driven (1 = released).
REQ-013 SHALL have port SCLK  output  1  serial clock.
REQ-014 SHALL have port DOUT  output  DATA_W  last word read.
REQ-015 SHALL have port DOUT_VALID  output  1  one-cycle pulse, DOUT updated.
REQ-016 SHALL have ports BUSY (1, high when not IDLE), DONE (1, one-cycle pulse at burst end), ACK_ERR (1, sticky NACK flag).

Function
REQ-017 SHALL implement states IDLE, LOAD, BIT_LO, BIT_HI, ACK_LO, ACK_HI, NEXT, FINISH.
REQ-018 SHALL assert DIN_READY only in IDLE and NEXT; accept = DIN_READY && DIN_VALID captures DIN, LAST, PERFORM_READ, then -> LOAD.
REQ-019 SHALL spend exactly 1 cycle in LOAD (SCLK=0, first bit on DATA_OUT), then CLK_DIV cycles in each BIT_LO and BIT_HI phase.
REQ-020 SHALL drive SCLK=0 in LOAD/BIT_LO/ACK_LO/NEXT/FINISH/IDLE, SCLK=1 in BIT_HI/ACK_HI.
REQ-021 SHALL change DATA_OUT only on entry to LOAD, BIT_LO or ACK_LO, never while SCLK=1.
REQ-022 SHALL shift bits per LSB_FIRST; after DATA_W BIT_HI phases go to ACK_LO, else BIT_LO.
REQ-023 Write word: DATA_OUT = data bit; in ACK phase DATA_OUT=1, SDA_IN sampled on last cycle of ACK_HI.
REQ-024 Read word: DATA_OUT=1 for data bits; SDA_IN sampled on last cycle of each BIT_HI into shift register; ACK phase drives 0 if LAST=0, 1 (NACK) if LAST=1.
REQ-025 Read word SHALL load DOUT and pulse DOUT_VALID on the cycle leaving ACK_HI.
REQ-026 After ACK_HI -> FINISH if LAST or abort (REQ-033), else -> NEXT; NEXT holds SCLK low indefinitely until accept.
REQ-027 FINISH SHALL last 1 cycle, assert DONE, then -> IDLE; DONE and DIN_READY never high together.
REQ-028 Each word SHALL produce exactly DATA_W+1 SCLK high pulses, each CLK_DIV cycles wide.
REQ-029 DIN_VALID during non-ready states SHALL be ignored; DIN changes after accept SHALL not affect the word.
REQ-030 ACK_ERR SHALL clear on accept from IDLE, set on a sampled write NACK, hold until next burst.

Reset
REQ-031 RST_N low SHALL immediately force IDLE, SCLK=0, DATA_OUT=0, DOUT=0, DOUT_VALID=0, DONE=0, ACK_ERR=0, BUSY=0, all counters 0; DIN_READY=1 after release.
REQ-032 Reset mid-word SHALL abandon the word with no DONE or DOUT_VALID pulse.

Configuration
REQ-033 With I2C_ACK_CHECK_EN defined, a write NACK SHALL set ACK_ERR and end the burst via FINISH after that ACK phase; without it, ACK_ERR is constant 0, ACK sampled but ignored, burst continues to LAST.

Verification
REQ-034 DATA_W=8, CLK_DIV=4: write 0xA5 LAST=1, SDA_IN=0 -> bits 1,0,1,0,0,1,0,1 on DATA_OUT, 9 SCLK pulses of 4 cycles, DONE 1 pulse, ACK_ERR=0.
REQ-035 Burst 0x12,0x34,0x56 with DIN_VALID delayed 10 cycles before word 2 -> SCLK low throughout NEXT wait, 27 SCLK pulses, one DONE.
REQ-036 Read, LAST=0 then LAST=1, SDA_IN stream 0x3C then 0xC3 -> DOUT_VALID twice with 0x3C, 0xC3; ACK bits 0 then 1.
REQ-037 With I2C_ACK_CHECK_EN, write 0x11,0x22 and SDA_IN=1 in first ACK -> ACK_ERR=1, DONE after word 1, 0x22 never shifted; without macro both words sent, ACK_ERR=0.
REQ-038 LSB_FIRST=1, DATA_W=4, CLK_DIV=1: write 0x6 -> bits 0,1,1,0; each SCLK high 1 cycle.
REQ-039 RST_N low during bit 4 of 0xFF -> outputs reset same cycle, no DONE; next write 0x81 completes normally.
